my_ram8: RTL and testbench

MY_RAM8 -- requirements
Module: my_ram8

---
 rtl/my_ram8_pkg.sv | 28 ++
 rtl/my_register.sv | 31 +++
 rtl/my_ram8.sv | 65 ++++++
 tb/tb_my_ram8.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/my_ram8_pkg.sv
// my_ram8_pkg: shared constants, types and the load demultiplex for the my_ram8 8-word RAM.
//
// Contents:
//   DEPTH         number of words (8)
//   ADDR_W        address width in bits (3)
//   DEFAULT_WIDTH default data word width in bits (16)
//   addr_t        address type
//   demux8()      steers a single load enable onto one of DEPTH word enables
package my_ram8_pkg;

  localparam int unsigned DEPTH         = 8;
  localparam int unsigned ADDR_W        = 3;
  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef logic [ADDR_W-1:0] addr_t;

  // 8-way load demultiplex. Each output bit is gated by en, so an unknown
  // select with en=0 still yields all-zero enables and no word is written.
  function automatic logic [DEPTH-1:0] demux8(input logic en, input addr_t sel);
    logic [DEPTH-1:0] onehot;
    onehot = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      onehot[k] = en && (sel == ADDR_W'(k));
    end
    return onehot;
  endfunction

endpackage

// File: rtl/my_register.sv
// my_register: WIDTH-bit storage word with load enable and asynchronous active-low clear.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low clear (q goes to 0 immediately)
//   i_d     write data
//   i_load  capture i_d on the next rising clk edge
//   o_q     stored word
module my_register #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_load,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/my_ram8.sv
// my_ram8: 8-word x WIDTH-bit RAM built from eight my_register words.
//
// Ports:
//   clk      rising-edge clock for all writes
//   rst_n    asynchronous active-low reset; clears every word (and the read register)
//   in       write data
//   load     write enable for the addressed word
//   address  word select 0..7
//   out      read data of the addressed word
//
// Configuration:
//   MY_RAM8_READ_REG_EN undefined -> out is combinational (zero-cycle read latency).
//   MY_RAM8_READ_REG_EN defined   -> out is registered (one-cycle latency, write-first).
module my_ram8
  import my_ram8_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  output logic [WIDTH-1:0]  out
);

  logic [DEPTH-1:0] w_word_en;
  logic [WIDTH-1:0] w_words [DEPTH];
  logic [WIDTH-1:0] w_rd_data;

  assign w_word_en = demux8(load, address);

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    my_register #(
      .WIDTH (WIDTH)
    ) u_word (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_d    (in),
      .i_load (w_word_en[g]),
      .o_q    (w_words[g])
    );
  end

  // 8-way WIDTH-bit read multiplex.
  assign w_rd_data = w_words[address];

`ifdef MY_RAM8_READ_REG_EN
  logic [WIDTH-1:0] r_out;

  // Write-first: load always targets the read address, so forward in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
    end else begin
      r_out <= load ? in : w_rd_data;
    end
  end

  assign out = r_out;
`else
  assign out = w_rd_data;
`endif

endmodule

// File: tb/tb_my_ram8.sv
// tb_my_ram8: self-checking bench for my_ram8 (WIDTH=16). Directed steps followed by
// random traffic, checked against an 8-entry array model of the memory.
module tb_my_ram8;

  logic        clk;
  logic        rst_n;
  logic [15:0] in;
  logic        load;
  logic [2:0]  address;
  logic [15:0] out;

  logic [15:0] mem [8];
  logic [15:0] exp_reg;
  int          n_checks;
  int          n_fail;
  bit          clk_en;

  my_ram8 #(
    .WIDTH (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (in),
    .load    (load),
    .address (address),
    .out     (out)
  );

  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check before and after the rising edge.
  task automatic step(input string tag, input logic ld, input logic [2:0] a,
                      input logic [15:0] d);
    @(negedge clk);
    load    = ld;
    address = a;
    in      = d;
    #1;
`ifdef MY_RAM8_READ_REG_EN
    chk({tag, "_pre"}, out, exp_reg);
`else
    chk({tag, "_pre"}, out, mem[a]);
`endif
    @(posedge clk);
    if (ld) mem[a] = d;
    exp_reg = mem[a];
    #1;
    chk({tag, "_post"}, out, mem[a]);
  endtask

  task automatic read_all(input string tag);
    for (int k = 0; k < 8; k++) step(tag, 1'b0, 3'(k), 16'($urandom));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clk_en   = 1'b0;
    load     = 1'b0;
    address  = 3'd0;
    in       = 16'h0;
    for (int k = 0; k < 8; k++) mem[k] = 16'h0;
    exp_reg = 16'h0;

    // Reset with no clock running: every address reads zero.
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) begin
      address = 3'(k);
      #1;
      chk("reset_sweep", out, 16'h0000);
    end

    clk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Writes of 0x1111*k, then readback.
    for (int k = 0; k < 8; k++) step("write_k", 1'b1, 3'(k), 16'(16'h1111 * k));
    for (int k = 0; k < 8; k++) step("read_k", 1'b0, 3'(k), 16'h0);
    for (int k = 0; k < 8; k++) chk("model_k", mem[k], 16'(16'h1111 * k));

    // Isolation over all-zero memory.
    for (int k = 0; k < 8; k++) step("clear", 1'b1, 3'(k), 16'h0000);
    step("iso_wr", 1'b1, 3'd5, 16'hFFFF);
    read_all("iso_rd");

    // Hold: load=0 with junk data for 10 edges at every address.
    for (int k = 0; k < 8; k++)
      for (int n = 0; n < 10; n++) step("hold", 1'b0, 3'(k), 16'hBEEF);
    read_all("hold_rd");

    // Unknown address with load=0 must not write anything.
    @(negedge clk);
    load    = 1'b0;
    address = 3'bxxx;
    in      = 16'hDEAD;
    @(posedge clk);
    @(negedge clk);
    address = 3'd0;
    @(posedge clk);
    #1;
    exp_reg = mem[0];
    read_all("xaddr_rd");

    // Read-during-write at address 3.
    step("rdw_setup", 1'b1, 3'd3, 16'h00AA);
    step("rdw", 1'b1, 3'd3, 16'h0055);
    step("rdw_other", 1'b0, 3'd6, 16'h0);
    step("rdw_back", 1'b0, 3'd3, 16'h0);

    // Reset pulse while load=1 at address 2; reset wins over the write.
    step("rst_setup", 1'b1, 3'd2, 16'h1234);
    @(negedge clk);
    load    = 1'b1;
    address = 3'd2;
    in      = 16'h5555;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out", out, 16'h0000);
    for (int k = 0; k < 8; k++) mem[k] = 16'h0;
    exp_reg = 16'h0;
    @(posedge clk);
    #1;
    chk("rst_over_edge", out, 16'h0000);
    @(negedge clk);
    load  = 1'b0;
    rst_n = 1'b1;
    step("rst_rd2", 1'b0, 3'd2, 16'h0);
    step("rst_wr2", 1'b1, 3'd2, 16'h4321);
    read_all("rst_rd_all");

    // Random traffic against the array model.
    for (int n = 0; n < 300; n++)
      step("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
    read_all("rand_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
